// File: rtl/icache_responder.sv
// Direct-mapped instruction cache in front of the fetch stage.
// A miss stalls fetch while the 4-word line is refilled from a request/valid memory burst.
module icache_responder #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iAddr,
    output logic [31:0] Instr,
    output logic        Stall,
    input  logic        Inv,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemValid,
    input  logic [31:0] MemData
);
    localparam int L  = $clog2(LINES);
    localparam int TW = 28 - L;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t           state_q, state_d;
    logic [31:0]      data_q [LINES][4];
    logic [TW-1:0]    tag_q  [LINES];
    logic [LINES-1:0] valid_q, valid_d;
    logic [27:0]      base_q, base_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d;

    logic [L-1:0]     idx, ridx;
    logic [TW-1:0]    tag, rtag;
    logic [1:0]       off;
    logic             hit;
    logic             last;
    logic             unused_addr;

    assign idx         = iAddr[3+L:4];
    assign tag         = iAddr[31:4+L];
    assign off         = iAddr[3:2];
    assign unused_addr = ^iAddr[1:0];

    // Refill target comes only from the base latched at the miss.
    assign ridx = base_q[L-1:0];
    assign rtag = base_q[27:L];

    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign Instr   = data_q[idx][off];
    assign MemAddr = {base_q, 4'b0000};
    assign last    = (state_q == REFILL) && MemValid && (cnt_q == 2'd3);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        Stall   = 1'b1;
        MemReq  = 1'b0;
        case (state_q)
            IDLE: begin
                Stall = ~hit;
                if (Inv) begin
                    valid_d = '0;
                end
                if (!hit) begin
                    state_d = REFILL;
                    base_d  = iAddr[31:4];
                    cnt_d   = 2'd0;
                end
            end
            REFILL: begin
                MemReq = 1'b1;
                if (Inv) begin
                    pend_d = 1'b1;
                end
                if (MemValid) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = IDLE;
                        pend_d  = 1'b0;
                        // An invalidate seen at any point of the burst also drops the new line.
                        if (pend_q || Inv) begin
                            valid_d = '0;
                        end else begin
                            valid_d[ridx] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            base_q  <= '0;
            cnt_q   <= 2'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == REFILL && MemValid) begin
            data_q[ridx][cnt_q] <= MemData;
        end
        if (last) begin
            tag_q[ridx] <= rtag;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: expected instruction words are queued when a
// fetch is issued and checked when the cache reports the fetch complete.
module tb_icache_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iAddr;
    logic [31:0] Instr;
    logic        Stall;
    logic        Inv;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemValid;
    logic [31:0] MemData;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    icache_responder #(.LINES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .iAddr    (iAddr),
        .Instr    (Instr),
        .Stall    (Stall),
        .Inv      (Inv),
        .MemReq   (MemReq),
        .MemAddr  (MemAddr),
        .MemValid (MemValid),
        .MemData  (MemData)
    );

    always #5 clk = ~clk;

    // Backing memory contents; line 0 holds 0x11,0x22,0x33,0x44.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {30'h0, a[3:2]} + 32'd1;
        if (a[31:4] == 28'h0) return 32'h11 * w;
        return {a[31:2], 2'b10} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the miss cycle; returns at the start of the cycle after the 4th word.
    task automatic refill(input logic [31:0] base, input int gap, input logic redirect,
                          input logic [31:0] alt, input int inv_w);
        logic [31:0] keep;
        keep = iAddr;
        tick();
        for (int w = 0; w < 4; w++) begin
            for (int g = 0; g < gap; g++) begin
                MemValid = 1'b0;
                Inv      = 1'b0;
                if (redirect) iAddr = alt;
                #1;
                chk("gap_memreq", 32'(MemReq), 32'd1);
                chk("gap_memaddr", MemAddr, base);
                chk("gap_stall", 32'(Stall), 32'd1);
                tick();
            end
            MemValid = 1'b1;
            MemData  = mem_word(base + 32'(4 * w));
            Inv      = (w == inv_w);
            if (w == 3) iAddr = keep;
            #1;
            chk("burst_memreq", 32'(MemReq), 32'd1);
            chk("burst_memaddr", MemAddr, base);
            chk("burst_stall", 32'(Stall), 32'd1);
            tick();
        end
        MemValid = 1'b0;
        Inv      = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic hit, input int gap = 0,
                         input logic redirect = 1'b0, input logic [31:0] alt = 32'h0);
        iAddr    = a;
        MemValid = 1'b0;
        #1;
        exp_q.push_back(mem_word(a));
        chk("fetch_stall", 32'(Stall), hit ? 32'd0 : 32'd1);
        chk("fetch_memreq", 32'(MemReq), 32'd0);
        if (!hit) begin
            refill({a[31:4], 4'b0000}, gap, redirect, alt, -1);
            #1;
            chk("post_fill_stall", 32'(Stall), 32'd0);
            chk("post_fill_memreq", 32'(MemReq), 32'd0);
        end
        chk("instr", Instr, exp_q.pop_front());
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        iAddr    = 32'h0;
        Inv      = 1'b0;
        MemValid = 1'b0;
        MemData  = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_stall", 32'(Stall), 32'd1);
        chk("reset_memreq", 32'(MemReq), 32'd0);
        chk("reset_memaddr", MemAddr, 32'h0);

        // First fill, then hits on the rest of the line.
        fetch(32'h0, 1'b0);
        fetch(32'h4, 1'b1);
        fetch(32'h8, 1'b1);
        fetch(32'hC, 1'b1);

        // Conflicting tags on index 0.
        fetch(32'h100, 1'b0);
        fetch(32'h0, 1'b0);
        fetch(32'h4, 1'b1);

        // Gapped burst with iAddr wandering to another line mid-fill.
        fetch(32'h34, 1'b0, 1, 1'b1, 32'h240);
        fetch(32'h38, 1'b1);
        fetch(32'h240, 1'b0);

        // Invalidate in IDLE.
        iAddr = 32'h0;
        Inv   = 1'b1;
        #1;
        chk("inv_idle_hit_before", 32'(Stall), 32'd0);
        tick();
        Inv = 1'b0;
        fetch(32'h0, 1'b0);

        // Invalidate during a refill of 0x20: line must not become valid.
        iAddr = 32'h20;
        #1;
        chk("inv_refill_miss", 32'(Stall), 32'd1);
        refill(32'h20, 0, 1'b0, 32'h0, 1);
        #1;
        chk("inv_refill_still_miss", 32'(Stall), 32'd1);
        refill(32'h20, 0, 1'b0, 32'h0, -1);
        #1;
        chk("inv_refill_second_stall", 32'(Stall), 32'd0);
        chk("inv_refill_instr", Instr, mem_word(32'h20));
        tick();

        // Reset after two words of a burst.
        iAddr = 32'h50;
        #1;
        chk("rst_mid_miss", 32'(Stall), 32'd1);
        tick();
        for (int w = 0; w < 2; w++) begin
            MemValid = 1'b1;
            MemData  = mem_word(32'h50 + 32'(4 * w));
            #1;
            chk("rst_mid_memreq", 32'(MemReq), 32'd1);
            tick();
        end
        MemValid = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        iAddr    = 32'h58;
        MemValid = 1'b1;
        MemData  = 32'hDEAD_BEEF;
        #1;
        chk("rst_mid_memreq_drop", 32'(MemReq), 32'd0);
        chk("rst_mid_memaddr", MemAddr, 32'h0);
        chk("rst_mid_stall", 32'(Stall), 32'd1);
        refill(32'h50, 0, 1'b0, 32'h0, -1);
        #1;
        chk("rst_refill_stall", 32'(Stall), 32'd0);
        chk("rst_refill_instr", Instr, mem_word(32'h58));
        tick();
        fetch(32'h50, 1'b1);
        fetch(32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
